ov7670_pixel_packer: RTL and testbench

//  Camera-side capture stage: samples the OV7670 byte stream (RGB444, 2 bytes/pixel), packs pixels

---
 rtl/ov7670_pkg.sv | 34 +++
 rtl/ov7670_pixel_packer_edge_detect.sv | 29 ++
 rtl/ov7670_pixel_packer.sv | 176 +++++++++++++++++
 tb/tb_ov7670_pixel_packer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture path: geometry defaults,
// capture FSM states and RGB444 packing helper.
package ov7670_pkg;

    localparam int unsigned PIX_W        = 12;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned ADDR_W_DEF   = 17;

    // RGB444 field positions inside the packed 12-bit pixel
    localparam int unsigned CH_W  = 4;
    localparam int unsigned R_LSB = 8;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [PIX_W-1:0] pack_rgb444(
        input logic [CH_W-1:0] r,
        input logic [CH_W-1:0] g,
        input logic [CH_W-1:0] b
    );
        logic [PIX_W-1:0] p;
        p = '0;
        p[R_LSB +: CH_W] = r;
        p[G_LSB +: CH_W] = g;
        p[B_LSB +: CH_W] = b;
        return p;
    endfunction

endpackage

// File: rtl/ov7670_pixel_packer_edge_detect.sv
// Registers a single-bit camera signal and produces one-cycle rise/fall
// pulses aligned with the registered level.
module ov7670_pixel_packer_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    // Sample the pin and keep one cycle of history; both reset low so a
    // signal that is already low after reset never yields a false fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            level <= din;
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/ov7670_pixel_packer.sv
// OV7670 capture stage: packs RGB444 byte pairs into 12-bit pixels,
// keeps every second pixel of every second line and drives the frame
// buffer write port. Tracks frame sync, counts frames, flags bad lines.
module ov7670_pixel_packer
    import ov7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  dout,
    output logic              we,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              line_err
);

    // x counts up to H_ACTIVE+1 and then sticks, so overlong lines never wrap
    localparam int unsigned X_W = $clog2(H_ACTIVE + 2);
    localparam int unsigned Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_END     = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_END     = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / 2);

    state_t state, state_nxt;

    logic vsync_q, vsync_rise, vsync_fall;
    logic href_q, href_rise, href_fall;
    logic [7:0] d_q;

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] line_base;
    logic              phase;
    logic              in_line;
    logic [CH_W-1:0]   r_lat;

    logic enter_active, line_live, pix_done, store, line_end, frame_end, abort;

    ov7670_pixel_packer_edge_detect u_vsync_ed (
        .clk   (pclk),
        .rst   (reset),
        .din   (vsync),
        .level (vsync_q),
        .rise  (vsync_rise),
        .fall  (vsync_fall)
    );

    ov7670_pixel_packer_edge_detect u_href_ed (
        .clk   (pclk),
        .rst   (reset),
        .din   (href),
        .level (href_q),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    // Data byte gets the same single input register as vsync/href
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            d_q <= '0;
        end else begin
            d_q <= d;
        end
    end

    // FSM state register
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: arm on the end of vertical blanking, disarm on its start
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SYNC:   if (vsync_fall) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (vsync_rise) state_nxt = ST_SYNC;
            default:   state_nxt = ST_SYNC;
        endcase
    end

    // FSM outputs: per-cycle capture decisions from the registered inputs.
    // A line only counts if its HREF rose while armed, so a line already in
    // flight when VSYNC falls is skipped rather than captured from mid-line.
    always_comb begin
        enter_active = 1'b0;
        line_live    = 1'b0;
        pix_done     = 1'b0;
        store        = 1'b0;
        line_end     = 1'b0;
        frame_end    = 1'b0;
        abort        = 1'b0;
        if (state == ST_SYNC) begin
            enter_active = vsync_fall;
        end else begin
            line_live = href_q && (href_rise || in_line) && !vsync_q;
            pix_done  = line_live && phase;
            store     = pix_done && !x[0] && !y[0] && (x < X_END) && (y < Y_END);
            line_end  = href_fall && in_line;
            frame_end = vsync_rise && (y != '0);
            abort     = vsync_rise && href_q;
        end
    end

    // Pixel/line counters and line-base accumulation
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            phase     <= 1'b0;
            in_line   <= 1'b0;
            r_lat     <= '0;
        end else if (enter_active) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            phase     <= 1'b0;
            in_line   <= 1'b0;
        end else if (state == ST_ACTIVE) begin
            if (vsync_rise) begin
                phase   <= 1'b0;
                in_line <= 1'b0;
            end else if (line_live) begin
                in_line <= 1'b1;
                if (!phase) begin
                    r_lat <= d_q[3:0];
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (x <= X_END) x <= x + 1'b1;
                end
            end else if (line_end) begin
                phase   <= 1'b0;
                in_line <= 1'b0;
                x       <= '0;
                if (y < Y_END) begin
                    y <= y + 1'b1;
                    if (y[0]) line_base <= line_base + LINE_STEP;
                end
            end
        end
    end

    // Write port, frame bookkeeping and sticky line error
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            addr        <= '0;
            dout        <= '0;
            we          <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            line_err    <= 1'b0;
        end else begin
            we         <= store;
            frame_done <= frame_end;
            if (store) begin
                dout <= pack_rgb444(r_lat, d_q[7:4], d_q[3:0]);
                addr <= line_base + ADDR_W'(x >> 1);
            end
            if (frame_end) frame_count <= frame_count + 8'd1;
            if (abort || (line_end && (phase || x != X_END))) line_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ov7670_pixel_packer.sv
// Self-checking bench for ov7670_pixel_packer on a reduced 32x12 geometry.
module tb_ov7670_pixel_packer;

    localparam int H    = 32;
    localparam int V    = 12;
    localparam int AW   = 7;
    localparam int HALF = H / 2;

    logic          pclk = 1'b0;
    logic          reset;
    logic          vsync;
    logic          href;
    logic [7:0]    d;
    logic [AW-1:0] addr;
    logic [11:0]   dout;
    logic          we;
    logic          frame_done;
    logic [7:0]    frame_count;
    logic          line_err;

    ov7670_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .d           (d),
        .addr        (addr),
        .dout        (dout),
        .we          (we),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .line_err    (line_err)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int unsigned a;
        int unsigned px;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   last_addr = 0;
    logic done_prev = 1'b0;

    // reference model state
    bit   armed = 0;
    int   line_idx = 0;
    int   exp_count = 0;
    int   exp_done = 0;
    bit   exp_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // write-port scoreboard and frame_done monitor
    always @(negedge pclk) begin : mon
        wr_t e;
        if (!reset) begin
            if (we === 1'b1) begin
                wr_cnt++;
                last_addr = int'(addr);
                if (exp_q.size() == 0) begin
                    check("spurious_we", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", 32'(addr), e.a);
                    check("dout", 32'(dout), e.px);
                end
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                check("done_width", 32'(done_prev), 0);
            end
            done_prev = frame_done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            href = 1'b0;
            d    = 8'($urandom);
        end
    endtask

    // mode 0: {0A,BC}; 1: pixel-index encoded; 2: random bytes
    task automatic send_line(input int nbytes, input int mode, input int blank, input bit lat);
        logic [7:0] b[$];
        wr_t w;
        int p;
        for (int i = 0; i < nbytes; i++) begin
            p = i / 2;
            case (mode)
                0:       b.push_back((i % 2 == 0) ? 8'h0A : 8'hBC);
                1:       b.push_back((i % 2 == 0) ? {4'($urandom), 4'(p)} : 8'(p * 5 + 1));
                default: b.push_back(8'($urandom));
            endcase
        end
        if (armed) begin
            if (line_idx < V && line_idx % 2 == 0) begin
                for (int q = 0; q < nbytes / 2 && q < H; q += 2) begin
                    w.a  = (line_idx / 2) * HALF + q / 2;
                    w.px = 32'({b[2*q][3:0], b[2*q+1]});
                    exp_q.push_back(w);
                end
            end
            if (nbytes % 2 != 0 || nbytes / 2 != H) exp_err = 1;
            line_idx++;
        end
        for (int i = 0; i < nbytes; i++) begin
            @(negedge pclk);
            if (lat && i == 2) check("lat_1cyc", 32'(we), 0);
            if (lat && i == 3) check("lat_2cyc", 32'(we), 1);
            href = 1'b1;
            d    = b[i];
        end
        idle(blank + 1);
    endtask

    task automatic vsync_pulse(input int hi, input int lo);
        @(negedge pclk);
        href  = 1'b0;
        vsync = 1'b1;
        if (armed && line_idx > 0) begin
            exp_count++;
            exp_done++;
        end
        armed    = 1;
        line_idx = 0;
        repeat (hi) @(negedge pclk);
        vsync = 1'b0;
        repeat (lo) @(negedge pclk);
    endtask

    task automatic frame(input int mode, input int nlines);
        for (int l = 0; l < nlines; l++) send_line(2 * H, mode, 3, 0);
        vsync_pulse(3, 2);
    endtask

    task automatic checkpoint(input string tag);
        idle(4);
        check({tag, "_count"}, 32'(frame_count), 32'(exp_count % 256));
        check({tag, "_err"}, 32'(line_err), 32'(exp_err));
        check({tag, "_qempty"}, exp_q.size(), 0);
        check({tag, "_done"}, done_cnt, exp_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, d0, n, r, len;
        reset = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        d     = 8'h00;
        repeat (3) @(negedge pclk);
        check("rst_addr", 32'(addr), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_we", 32'(we), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_count", 32'(frame_count), 0);
        check("rst_err", 32'(line_err), 0);
        @(negedge pclk);
        reset = 1'b0;

        // stream already running after reset: nothing stored until a vsync pulse
        repeat (3) send_line(2 * H, 2, 3, 0);
        vsync_pulse(3, 2);
        checkpoint("mid");

        // full constant frame
        wr0 = wr_cnt;
        frame(0, V);
        checkpoint("full");
        check("full_writes", wr_cnt - wr0, HALF * V / 2);
        check("last_addr", last_addr, HALF * V / 2 - 1);

        // index-encoded frame, write latency on first stored pixel
        send_line(2 * H, 1, 3, 1);
        for (int l = 1; l < V; l++) send_line(2 * H, 1, 3, 0);
        vsync_pulse(3, 2);
        checkpoint("xenc");

        // odd byte count on a stored line
        for (int l = 0; l < V; l++) send_line((l == 2) ? 2 * H - 1 : 2 * H, 2, 3, 0);
        vsync_pulse(3, 2);
        checkpoint("odd");

        // random frames: odd lengths, long/short lines, extra lines
        repeat (4) begin
            n = V - 2 + int'($urandom_range(0, 4));
            for (int l = 0; l < n; l++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      len = 2 * H + 2 * int'($urandom_range(1, 3));
                else if (r == 1) len = 2 * H - 2 * int'($urandom_range(1, 3));
                else if (r == 2) len = 2 * H - 1;
                else             len = 2 * H;
                send_line(len, 2, int'($urandom_range(3, 8)), 0);
            end
            vsync_pulse(int'($urandom_range(2, 5)), int'($urandom_range(2, 4)));
            checkpoint("rand");
        end

        // reset in the middle of an odd line
        for (int l = 0; l < 5; l++) send_line(2 * H, 2, 3, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            href = 1'b1;
            d    = 8'($urandom);
        end
        check("pre_reset_q", exp_q.size(), 0);
        @(negedge pclk);
        reset = 1'b1;
        #1;
        check("mrst_addr", 32'(addr), 0);
        check("mrst_dout", 32'(dout), 0);
        check("mrst_count", 32'(frame_count), 0);
        check("mrst_err", 32'(line_err), 0);
        repeat (3) begin
            @(negedge pclk);
            check("mrst_we", 32'(we), 0);
            check("mrst_fd", 32'(frame_done), 0);
        end
        armed     = 0;
        line_idx  = 0;
        exp_count = 0;
        exp_err   = 0;
        reset     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            href = 1'b1;
            d    = 8'($urandom);
        end
        idle(4);
        repeat (2) send_line(2 * H, 2, 3, 0);
        vsync_pulse(3, 2);
        frame(2, V);
        checkpoint("post_rst");

        // vsync rises while a line is in progress
        send_line(2 * H, 2, 3, 0);
        exp_err = 1;
        exp_count++;
        exp_done++;
        armed    = 1;
        line_idx = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            href = 1'b1;
            d    = 8'($urandom);
            if (i == 10) vsync = 1'b1;
        end
        @(negedge pclk);
        href = 1'b0;
        repeat (3) @(negedge pclk);
        vsync = 1'b0;
        idle(2);
        checkpoint("abort");

        // 256 short frames: frame_count wraps through zero
        d0 = done_cnt;
        for (int k = 0; k < 256; k++) begin
            send_line(2 * H, 0, 2, 0);
            vsync_pulse(2, 2);
            idle(2);
            if ((exp_count % 256) == 0) check("wrap_zero", 32'(frame_count), 0);
        end
        checkpoint("wrap");
        check("wrap_pulses", done_cnt - d0, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
